// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two SRAM requesters (CPU, loader), the arbiter and
// the SRAM pins. The arbiter uses the slave view; the environment that drives
// requests and models the SRAM uses the master view.
//
// Handshake: a requester raises req (with we/addr/wdata valid) and holds it
// until it sees its one-cycle ack; it must drop req no later than the edge
// that samples ack high. A req still high in the following IDLE cycle is a
// new request. rdata is valid from ack onward and is held until the next read
// by the same requester.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // CPU memory interface (MAR/MDR side)
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  // program-loader / debug port
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  // SRAM pins (strobes active-low)
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] Data_to_SRAM;
  logic [DATA_W-1:0] Data_from_SRAM;
  logic              OE;
  logic              WE;

  // status
  logic              busy;
  logic              grant_ldr;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output ADDR, Data_to_SRAM, OE, WE,
    input  Data_from_SRAM,
    output busy, grant_ldr
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  ADDR, Data_to_SRAM, OE, WE,
    output Data_from_SRAM,
    input  busy, grant_ldr
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares the single external SRAM port between the CPU and the program
// loader. Each access runs IDLE (arbitrate) -> SETUP -> STROBE (ACCESS_CYCLES)
// -> HOLD, so an access occupies ACCESS_CYCLES+3 cycles. Every output is a
// register; nothing passes combinationally from a request input to a pin.
module sram_port_arbiter #(
  parameter int ACCESS_CYCLES = 2,  // strobe low time, 1..15
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  sram_port_arbiter_if.slave      bus,
  output logic [1:0]              state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  // Counter value loaded in SETUP; STROBE ends when it reaches zero.
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       we_q;            // latched direction of the access in flight
  logic       last_grant_ldr;  // 1 = loader won the previous grant

  logic       pick_valid;
  logic       pick_ldr;
  logic       grant_fire;
  logic       strobe_last;

  assign state_dbg = state;

  // Round-robin pick: a lone requester wins; on a tie the side that did not
  // win last time goes next.
  always_comb begin
    pick_valid = 1'b0;
    pick_ldr   = 1'b0;
    if (bus.cpu_req && bus.ldr_req) begin
      pick_valid = 1'b1;
      pick_ldr   = ~last_grant_ldr;
    end else if (bus.cpu_req) begin
      pick_valid = 1'b1;
      pick_ldr   = 1'b0;
    end else if (bus.ldr_req) begin
      pick_valid = 1'b1;
      pick_ldr   = 1'b1;
    end
  end

  assign grant_fire  = (state == IDLE) && pick_valid;
  assign strobe_last = (state == STROBE) && (cnt == 4'd0);

  // Sequencer: state, strobe-length counter and the busy flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= SETUP;
            bus.busy <= 1'b1;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CNT_LOAD;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  // Latch the winner's request at grant; address and write data then stay on
  // the pins through HOLD and keep their last value while IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.ADDR         <= '0;
      bus.Data_to_SRAM <= '0;
      we_q             <= 1'b0;
      bus.grant_ldr    <= 1'b0;
      last_grant_ldr   <= 1'b1;
    end else if (grant_fire) begin
      bus.ADDR         <= pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
      bus.Data_to_SRAM <= pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
      we_q             <= pick_ldr ? bus.ldr_we    : bus.cpu_we;
      bus.grant_ldr    <= pick_ldr;
      last_grant_ldr   <= pick_ldr;
    end
  end

  // Strobes: only one of OE/WE goes low, and only for the STROBE cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.OE <= 1'b1;
      bus.WE <= 1'b1;
    end else if (state == SETUP) begin
      bus.OE <= we_q;
      bus.WE <= ~we_q;
    end else if (strobe_last || state != STROBE) begin
      bus.OE <= 1'b1;
      bus.WE <= 1'b1;
    end
  end

  // Completion: capture read data on the final STROBE edge and pulse the
  // owner's ack during HOLD. The other requester's rdata is left alone.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bus.cpu_ack   <= 1'b0;
      bus.ldr_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ldr_rdata <= '0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.ldr_ack <= 1'b0;
      if (strobe_last) begin
        if (bus.grant_ldr) begin
          bus.ldr_ack <= 1'b1;
          if (!we_q) begin
            bus.ldr_rdata <= bus.Data_from_SRAM;
          end
        end else begin
          bus.cpu_ack <= 1'b1;
          if (!we_q) begin
            bus.cpu_rdata <= bus.Data_from_SRAM;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a table of single accesses through a default
// build, hand sequences for mid-access changes, reset abort and contention,
// and a read through an ACCESS_CYCLES=1 build.
module tb_sram_port_arbiter;

  localparam int A = 2;

  logic Clk;
  logic Reset;
  logic [1:0] state0;
  logic [1:0] state1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];

  sram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus0 ();
  sram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  sram_port_arbiter #(.ACCESS_CYCLES(A), .ADDR_W(16), .DATA_W(16)) dut0 (
    .Clk(Clk), .Reset(Reset), .bus(bus0), .state_dbg(state0)
  );

  sram_port_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(16), .DATA_W(16)) dut1 (
    .Clk(Clk), .Reset(Reset), .bus(bus1), .state_dbg(state1)
  );

  // ---------------- clock / SRAM models ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [15:0] mem [0:255];

  // SRAM model for dut0: preloaded during reset, written while WE is low.
  always @(posedge Clk) begin
    if (Reset) begin
      mem[8'h40] <= 16'h1234;
      mem[8'h10] <= 16'h1111;
      mem[8'h20] <= 16'h2222;
    end else if (!bus0.WE) begin
      mem[bus0.ADDR[7:0]] <= bus0.Data_to_SRAM;
    end
  end

  assign bus0.Data_from_SRAM = mem[bus0.ADDR[7:0]];
  assign bus1.Data_from_SRAM = (bus1.ADDR == 16'h0077) ? 16'hA5A5 : 16'h0000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One access on dut0 starting at a negedge with the arbiter idle.
  // chg_n > 0 rewrites the requester's addr/wdata at that cycle of the access.
  task automatic do_access(input bit is_ldr, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] exp_rd,
                           input int chg_n, input logic [15:0] chg_addr);
    logic [15:0] other_before;
    logic [15:0] exp_v;
    int n = 0;
    int oe_lo = 0;
    int we_lo = 0;
    bit got = 0;
    bit hold_ok = 1;
    bit excl_ok = 1;
    bit other_ok = 1;
    string tag;
    tag = $sformatf("%s_%s_%0h", is_ldr ? "ldr" : "cpu", wr ? "wr" : "rd", addr);
    exp_q.push_back(wr ? wdata : exp_rd);
    other_before = is_ldr ? bus0.cpu_rdata : bus0.ldr_rdata;
    if (is_ldr) begin
      bus0.ldr_req = 1'b1; bus0.ldr_we = wr; bus0.ldr_addr = addr; bus0.ldr_wdata = wdata;
    end else begin
      bus0.cpu_req = 1'b1; bus0.cpu_we = wr; bus0.cpu_addr = addr; bus0.cpu_wdata = wdata;
    end
    while (!got && n < 40) begin
      @(negedge Clk);
      n++;
      if (n == chg_n) begin
        if (is_ldr) begin bus0.ldr_addr = chg_addr; bus0.ldr_wdata = ~wdata; end
        else begin bus0.cpu_addr = chg_addr; bus0.cpu_wdata = ~wdata; end
      end
      if (!bus0.OE) oe_lo++;
      if (!bus0.WE) we_lo++;
      if (!bus0.OE && !bus0.WE) excl_ok = 0;
      if (bus0.busy && (bus0.ADDR !== addr || (wr && bus0.Data_to_SRAM !== wdata))) hold_ok = 0;
      if (is_ldr ? bus0.cpu_ack : bus0.ldr_ack) other_ok = 0;
      if (is_ldr ? bus0.ldr_ack : bus0.cpu_ack) got = 1;
    end
    if (is_ldr) bus0.ldr_req = 1'b0; else bus0.cpu_req = 1'b0;
    check({tag, "_ack_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(A + 2));
    check({tag, "_oe_low_cycles"}, 32'(oe_lo), wr ? 32'd0 : 32'(A));
    check({tag, "_we_low_cycles"}, 32'(we_lo), wr ? 32'(A) : 32'd0);
    check({tag, "_strobe_exclusive"}, 32'(excl_ok), 32'd1);
    check({tag, "_addr_data_hold"}, 32'(hold_ok), 32'd1);
    check({tag, "_other_ack_quiet"}, 32'(other_ok), 32'd1);
    check({tag, "_grant_ldr"}, 32'(bus0.grant_ldr), 32'(is_ldr));
    exp_v = exp_q.pop_front();
    if (wr) check({tag, "_sram_contents"}, 32'(mem[addr[7:0]]), 32'(exp_v));
    else check({tag, "_rdata"}, 32'(is_ldr ? bus0.ldr_rdata : bus0.cpu_rdata), 32'(exp_v));
    check({tag, "_other_rdata_kept"}, 32'(is_ldr ? bus0.cpu_rdata : bus0.ldr_rdata), 32'(other_before));
    @(negedge Clk);
    check({tag, "_ack_one_cycle"}, 32'(bus0.cpu_ack | bus0.ldr_ack), 32'd0);
    check({tag, "_idle_after"}, 32'(bus0.busy), 32'd0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    bit          is_ldr;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 0, 16'h0040, 16'h0000, 16'h1234};
    vecs[1] = '{1, 1, 16'h00FF, 16'hBEEF, 16'h0000};
    vecs[2] = '{1, 0, 16'h00FF, 16'h0000, 16'hBEEF};
    vecs[3] = '{0, 1, 16'h0003, 16'h5A5A, 16'h0000};
    vecs[4] = '{0, 0, 16'h0003, 16'h0000, 16'h5A5A};
    vecs[5] = '{1, 0, 16'h0040, 16'h0000, 16'h1234};

    Reset = 1'b1;
    bus0.cpu_req = 0; bus0.cpu_we = 0; bus0.cpu_addr = 0; bus0.cpu_wdata = 0;
    bus0.ldr_req = 0; bus0.ldr_we = 0; bus0.ldr_addr = 0; bus0.ldr_wdata = 0;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = 0; bus1.cpu_wdata = 0;
    bus1.ldr_req = 0; bus1.ldr_we = 0; bus1.ldr_addr = 0; bus1.ldr_wdata = 0;
    repeat (3) @(negedge Clk);

    // reset state
    check("rst_oe", 32'(bus0.OE), 32'd1);
    check("rst_we", 32'(bus0.WE), 32'd1);
    check("rst_acks", 32'({bus0.cpu_ack, bus0.ldr_ack}), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_addr", 32'(bus0.ADDR), 32'd0);
    check("rst_wdata", 32'(bus0.Data_to_SRAM), 32'd0);
    check("rst_rdata", 32'({bus0.cpu_rdata, bus0.ldr_rdata}), 32'd0);
    check("rst_grant_ldr", 32'(bus0.grant_ldr), 32'd0);
    check("rst_state", 32'(state0), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // table of single accesses
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i].is_ldr, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 0, 16'h0);
    end

    // random write by one side, read back by the other
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ra;
      logic [15:0] rd;
      bit side;
      ra = 16'($urandom_range(16'h0080, 16'h00BF));
      rd = 16'($urandom_range(0, 16'hFFFF));
      side = 1'($urandom_range(0, 1));
      do_access(side, 1, ra, rd, 16'h0, 0, 16'h0);
      do_access(~side, 0, ra, 16'h0, rd, 0, 16'h0);
    end

    // request changed during STROBE: latched address/data must win
    do_access(0, 0, 16'h0010, 16'h0000, 16'h1111, 2, 16'h0020);
    do_access(1, 1, 16'h0090, 16'hC3C3, 16'h0, 2, 16'h0091);

    // reset in the middle of a write strobe
    begin
      bit quiet = 1;
      bus0.cpu_req = 1; bus0.cpu_we = 1; bus0.cpu_addr = 16'h0030; bus0.cpu_wdata = 16'h7777;
      repeat (2) @(negedge Clk);
      check("abort_we_low_before_reset", 32'(bus0.WE), 32'd0);
      Reset = 1'b1;
      #1;
      check("abort_strobes_high", 32'({bus0.OE, bus0.WE}), 32'h3);
      check("abort_busy", 32'(bus0.busy), 32'd0);
      check("abort_state", 32'(state0), 32'd0);
      bus0.cpu_req = 0;
      @(negedge Clk);
      Reset = 1'b0;
      repeat (6) begin
        @(negedge Clk);
        if (bus0.cpu_ack || bus0.ldr_ack || bus0.busy) quiet = 0;
      end
      check("abort_no_ack_after", 32'(quiet), 32'd1);
    end

    // contention: both requesters held high; CPU first, then alternating
    begin
      int n = 0;
      int k = 0;
      bit owner;
      logic [15:0] exp_n;
      for (int j = 0; j < 6; j++) exp_q.push_back(16'(A + 2 + j * (A + 3)));
      bus0.cpu_req = 1; bus0.cpu_we = 0; bus0.cpu_addr = 16'h0040;
      bus0.ldr_req = 1; bus0.ldr_we = 0; bus0.ldr_addr = 16'h0010;
      while (k < 6 && n < 80) begin
        @(negedge Clk);
        n++;
        if (bus0.cpu_ack && bus0.ldr_ack) check("cont_double_ack", 32'd1, 32'd0);
        if (bus0.cpu_ack || bus0.ldr_ack) begin
          owner = bus0.ldr_ack;
          exp_n = exp_q.pop_front();
          check($sformatf("cont_%0d_owner_ldr", k), 32'(owner), 32'(k % 2));
          check($sformatf("cont_%0d_cycle", k), 32'(n), 32'(exp_n));
          check($sformatf("cont_%0d_grant_ldr", k), 32'(bus0.grant_ldr), 32'(k % 2));
          check($sformatf("cont_%0d_rdata", k),
                32'(owner ? bus0.ldr_rdata : bus0.cpu_rdata),
                owner ? 32'h1111 : 32'h1234);
          k++;
        end
      end
      bus0.cpu_req = 0; bus0.ldr_req = 0;
      check("cont_ack_count", 32'(k), 32'd6);
      repeat (3) @(negedge Clk);
    end

    // ACCESS_CYCLES=1 build: 4-cycle access, ack two edges after the request
    begin
      int n = 0;
      int oe_lo = 0;
      int we_lo = 0;
      int busy_cyc = 0;
      bit got = 0;
      bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 16'h0077;
      while (!got && n < 20) begin
        @(negedge Clk);
        n++;
        if (!bus1.OE) oe_lo++;
        if (!bus1.WE) we_lo++;
        if (bus1.busy) busy_cyc++;
        if (bus1.cpu_ack) got = 1;
      end
      bus1.cpu_req = 0;
      check("ac1_ack_seen", 32'(got), 32'd1);
      check("ac1_latency", 32'(n), 32'd3);
      check("ac1_oe_low_cycles", 32'(oe_lo), 32'd1);
      check("ac1_we_low_cycles", 32'(we_lo), 32'd0);
      check("ac1_rdata", 32'(bus1.cpu_rdata), 32'hA5A5);
      check("ac1_busy_cycles", 32'(busy_cyc), 32'd3);
      @(negedge Clk);
      check("ac1_idle_after", 32'(bus1.busy), 32'd0);
      check("ac1_ldr_rdata_kept", 32'(bus1.ldr_rdata), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Sequences every access to the external 16-bit SRAM and shares the single SRAM port between two requesters: the CPU memory interface (MAR/MDR side) and a program-loader/debug port. Sits between the requesters and the SRAM pins. It owns the OE/WE strobe timing and the address/data hold timing, so neither requester drives SRAM control directly.

Parameters:
ACCESS_CYCLES, 2, number of cycles the OE or WE strobe is held low; legal range 1..15.
ADDR_W, 16, address width.
DATA_W, 16, data width.

Ports:
Clk  in  1  system clock, rising-edge.
Reset  in  1  asynchronous, active-high reset.
cpu_req  in  1  CPU access request; level, held until cpu_ack.
cpu_we  in  1  1 = write, 0 = read; valid while cpu_req is high.
cpu_addr  in  ADDR_W  CPU address.
cpu_wdata  in  DATA_W  CPU write data.
cpu_ack  out  1  one-cycle completion pulse to the CPU.
cpu_rdata  out  DATA_W  read data for the CPU; valid from cpu_ack onward.
ldr_req  in  1  loader request; same rules as cpu_req.
ldr_we  in  1  loader write enable.
ldr_addr  in  ADDR_W  loader address.
ldr_wdata  in  DATA_W  loader write data.
ldr_ack  out  1  one-cycle completion pulse to the loader.
ldr_rdata  out  DATA_W  read data for the loader.
ADDR  out  ADDR_W  SRAM address.
Data_to_SRAM  out  DATA_W  SRAM write data.
Data_from_SRAM  in  DATA_W  SRAM read data.
OE  out  1  SRAM output enable, active-low.
WE  out  1  SRAM write enable, active-low.
busy  out  1  high whenever the state is not IDLE.
grant_ldr  out  1  high while the current or last access belongs to the loader.

Behaviour:
- Reset (asynchronous) forces these values immediately:
  - state = IDLE, OE = 1, WE = 1, both acks = 0, busy = 0.
  - ADDR = 0, Data_to_SRAM = 0, cpu_rdata = 0, ldr_rdata = 0, grant_ldr = 0.
  - last_grant = loader, so the CPU wins the first tie.
- All outputs are registered. No combinational path runs from inputs to outputs.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - Requests are sampled at each edge.
  - If only one requester is asserting, grant it.
  - If both are asserting, grant the requester that is not last_grant (round-robin), then update last_grant.
  - On grant: latch the address, we and wdata of the granted requester into ADDR / Data_to_SRAM / we_q, set grant_ldr, go to SETUP.
- SETUP: one cycle. Address and data are stable, both strobes stay high. Counter is loaded with ACCESS_CYCLES-1.
- STROBE: OE=0 if reading, WE=0 if writing; the other strobe stays 1.
  - Counter decrements each cycle; the state lasts exactly ACCESS_CYCLES cycles.
  - Reads: Data_from_SRAM is captured into the granted requester's rdata at the final STROBE edge.
- HOLD: one cycle. Both strobes are high, while ADDR and Data_to_SRAM still hold their values (write hold time). The granted requester's ack = 1 for this cycle only. The next state is always IDLE.
- Latency: a request sampled at edge N produces an ack that is high between edges N+ACCESS_CYCLES+1 and N+ACCESS_CYCLES+2.
  - Total occupancy is ACCESS_CYCLES+3 cycles per access, including the IDLE arbitration cycle.
- Requester protocol:
  - Drop req at or before the edge that samples ack high.
  - A req still high in the following IDLE cycle is a new request.
  - Dropping req before ack is a protocol violation. The arbiter still completes the latched access and pulses ack.
- Input changes after grant have no effect on the access in flight; address, data and we were latched.
- ADDR and Data_to_SRAM keep their last values in IDLE. The unselected requester's rdata is never modified.
- OE and WE are never low in the same cycle, and never low outside STROBE.
- Reset during any state aborts the access: strobes go high at once, no ack is issued, rdata is not updated.

Test Plan:
- CPU read: SRAM model holds 0x1234 at 0x0040, cpu_req with addr 0x0040, we=0, ACCESS_CYCLES=2 -> OE low exactly 2 cycles, WE stays 1, cpu_ack one cycle at N+3, cpu_rdata=0x1234, ldr_ack stays 0.
- Loader write: addr 0x00FF, wdata 0xBEEF -> WE low 2 cycles with ADDR=0x00FF and Data_to_SRAM=0xBEEF stable from SETUP through HOLD, ldr_ack pulses, SRAM model holds 0xBEEF.
- Simultaneous contention: both requesters held high continuously (each re-requesting after its ack) -> first grant to CPU, then strictly alternating, ldr_ack and cpu_ack each every 10 cycles, grant_ldr toggles.
- Request changed mid-access: cpu_addr switches 0x0010→0x0020 during STROBE -> ADDR stays 0x0010, data for 0x0010 is returned.
- Reset mid-STROBE of a write -> OE and WE are 1 in the same cycle, no ack, busy=0; the next request completes normally with the CPU winning the tie.
- ACCESS_CYCLES=1 build: read of 0xA5A5 -> OE low 1 cycle, ack at N+2, full access occupies 4 cycles.
